// File: rtl/if_fetch_stage_pkg.sv
// Shared types for the IF stage: FSM states, reset PC and the buffered fetch entry.
// Imported by the fetch top and its one-entry fetch buffer.
package if_fetch_stage_pkg;

   localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;
   localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;

   typedef enum logic [1:0] {
      S_REQ  = 2'd0,
      S_HOLD = 2'd1,
      S_DROP = 2'd2
   } fetch_state_t;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } fetch_entry_t;

   // HOLD is the only state that keeps the memory request low.
   function automatic logic state_requests(fetch_state_t s);
      return (s != S_HOLD);
   endfunction

endpackage

// File: rtl/if_fetch_buf.sv
// One-entry {pc, instr} holding register for a fetch that retired under a stall.
// Load wins over clear; contents are visible the cycle after load, no backpressure of its own.
module if_fetch_buf
   import if_fetch_stage_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        load,
   input  logic        clear,
   input  logic [31:0] load_pc,
   input  logic [31:0] load_instr,
   output logic        buf_vld,
   output logic [31:0] buf_pc,
   output logic [31:0] buf_instr
);

   fetch_entry_t ent_q;
   logic         vld_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         vld_q <= 1'b0;
         ent_q <= '0;
      end else if (load) begin
         vld_q       <= 1'b1;
         ent_q.pc    <= load_pc;
         ent_q.instr <= load_instr;
      end else if (clear) begin
         vld_q <= 1'b0;
      end
   end

   assign buf_vld   = vld_q;
   assign buf_pc    = ent_q.pc;
   assign buf_instr = ent_q.instr;

endmodule

// File: rtl/if_fetch_stage.sv
// MIPS IF stage: PC register, imem request handshake and IF/ID register; 1-cycle fetch-to-ID latency.
// Stalls park a retired fetch in a one-entry buffer (request dropped); flushes mid-access drain the old request first.
module if_fetch_stage
   import if_fetch_stage_pkg::*;
#(
   parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
)
(
   input  logic        clk,
   input  logic        rst,
   input  logic        stall,
   input  logic        flush,
   input  logic [31:0] new_pc,
   output logic [31:0] if_pc,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ready,
   input  logic [31:0] imem_rdata,
   output logic [31:0] id_pc,
   output logic [31:0] id_instr,
   output logic        id_valid
);

   fetch_state_t state_q, state_d;

   logic [31:0] pc_q;
   logic [31:0] redir_q;
   logic [31:0] pc_nxt;
   logic        retire;

   logic        pc_ld;
   logic        pc_from_redir;
   logic        redir_ld;
   logic        id_ld_mem;
   logic        id_ld_buf;
   logic        id_bubble;
   logic        buf_ld;
   logic        buf_clr;

   logic        buf_vld;
   logic [31:0] buf_pc;
   logic [31:0] buf_instr;

   assign imem_req  = state_requests(state_q) && !rst;
   assign retire    = imem_req && imem_ready;
   assign if_pc     = pc_q;
   // In DROP pc_q still holds the abandoned address, so the address stays stable for the handshake.
   assign imem_addr = pc_q;
   assign pc_nxt    = pc_from_redir ? redir_q : new_pc;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_REQ;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      pc_ld         = 1'b0;
      pc_from_redir = 1'b0;
      redir_ld      = 1'b0;
      id_ld_mem     = 1'b0;
      id_ld_buf     = 1'b0;
      id_bubble     = 1'b0;
      buf_ld        = 1'b0;
      buf_clr       = 1'b0;

      case (state_q)
         S_REQ: begin
            if (flush) begin
               id_bubble = 1'b1;
               if (retire) begin
                  pc_ld = 1'b1;
               end else begin
                  redir_ld = 1'b1;
                  state_d  = S_DROP;
               end
            end else if (stall) begin
               if (retire) begin
                  buf_ld  = 1'b1;
                  state_d = S_HOLD;
               end
            end else if (retire) begin
               id_ld_mem = 1'b1;
               pc_ld     = 1'b1;
            end else begin
               id_bubble = 1'b1;
            end
         end

         S_HOLD: begin
            if (flush) begin
               buf_clr   = 1'b1;
               id_bubble = 1'b1;
               pc_ld     = 1'b1;
               state_d   = S_REQ;
            end else if (!stall) begin
               id_ld_buf = 1'b1;
               buf_clr   = 1'b1;
               pc_ld     = 1'b1;
               state_d   = S_REQ;
            end
         end

         S_DROP: begin
            id_bubble = 1'b1;
            if (flush) begin
               redir_ld = 1'b1;
            end
            // A flush landing on the retiring cycle is the newest target, so it bypasses redir_q.
            if (retire) begin
               pc_ld         = 1'b1;
               pc_from_redir = !flush;
               state_d       = S_REQ;
            end
         end

         default: begin
            state_d = S_REQ;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pc_q     <= RESET_PC;
         redir_q  <= RESET_PC;
         id_pc    <= 32'h0;
         id_instr <= NOP_INSTR;
         id_valid <= 1'b0;
      end else begin
         if (pc_ld) begin
            pc_q <= pc_nxt;
         end
         if (redir_ld) begin
            redir_q <= new_pc;
         end
         if (id_ld_mem) begin
            id_pc    <= pc_q;
            id_instr <= imem_rdata;
            id_valid <= 1'b1;
         end else if (id_ld_buf) begin
            id_pc    <= buf_pc;
            id_instr <= buf_instr;
            id_valid <= buf_vld;
         end else if (id_bubble) begin
            id_valid <= 1'b0;
         end
      end
   end

   if_fetch_buf u_fetch_buf (
      .clk        (clk),
      .rst        (rst),
      .load       (buf_ld),
      .clear      (buf_clr),
      .load_pc    (pc_q),
      .load_instr (imem_rdata),
      .buf_vld    (buf_vld),
      .buf_pc     (buf_pc),
      .buf_instr  (buf_instr)
   );

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed walk through the fetch scenarios, then randomized traffic against a queue-based reference model.
module tb_if_fetch_stage;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } ent_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        stall;
   logic        flush;
   logic [31:0] new_pc;
   logic [31:0] if_pc;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ready;
   logic [31:0] imem_rdata;
   logic [31:0] id_pc;
   logic [31:0] id_instr;
   logic        id_valid;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model: fetch address, IF/ID contents, parked fetch, pending redirect.
   logic        m_init = 1'b0;
   logic [31:0] m_pc;
   logic [31:0] m_id_pc;
   logic [31:0] m_id_instr;
   logic        m_id_valid;
   ent_t        m_park[$];
   logic [31:0] m_redir[$];

   if_fetch_stage dut (
      .clk        (clk),
      .rst        (rst),
      .stall      (stall),
      .flush      (flush),
      .new_pc     (new_pc),
      .if_pc      (if_pc),
      .imem_req   (imem_req),
      .imem_addr  (imem_addr),
      .imem_ready (imem_ready),
      .imem_rdata (imem_rdata),
      .id_pc      (id_pc),
      .id_instr   (id_instr),
      .id_valid   (id_valid)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] plus4(input logic [31:0] a);
      return a + 32'd4;
   endfunction

   task automatic model_edge();
      logic req;
      logic ret;
      req = !rst && (m_park.size() == 0);
      ret = req && imem_ready;
      if (rst) begin
         m_pc       = 32'h0000_3000;
         m_id_pc    = 32'h0;
         m_id_instr = 32'h0;
         m_id_valid = 1'b0;
         m_park.delete();
         m_redir.delete();
         m_init     = 1'b1;
      end else if (m_redir.size() != 0) begin
         // Old access still in flight: its data is thrown away whenever it lands.
         if (flush) m_redir[0] = new_pc;
         m_id_valid = 1'b0;
         if (ret) begin
            m_pc = flush ? new_pc : m_redir[0];
            m_redir.delete();
         end
      end else if (m_park.size() != 0) begin
         if (flush) begin
            m_park.delete();
            m_id_valid = 1'b0;
            m_pc       = new_pc;
         end else if (!stall) begin
            m_id_pc    = m_park[0].pc;
            m_id_instr = m_park[0].instr;
            m_id_valid = 1'b1;
            m_park.delete();
            m_pc       = new_pc;
         end
      end else if (flush) begin
         m_id_valid = 1'b0;
         if (ret) m_pc = new_pc;
         else     m_redir.push_back(new_pc);
      end else if (stall) begin
         if (ret) m_park.push_back('{pc: m_pc, instr: imem_rdata});
      end else if (ret) begin
         m_id_pc    = m_pc;
         m_id_instr = imem_rdata;
         m_id_valid = 1'b1;
         m_pc       = new_pc;
      end else begin
         m_id_valid = 1'b0;
      end
   endtask

   // One clock: apply inputs, compare outputs mid-cycle, advance model on the edge.
   task automatic cyc(input logic r, input logic s, input logic f, input logic rdy,
                      input logic [31:0] npc);
      rst        = r;
      stall      = s;
      flush      = f;
      imem_ready = rdy;
      new_pc     = npc;
      imem_rdata = $urandom;
      @(negedge clk);
      if (m_init) begin
         check_eq("imem_req", {31'h0, imem_req}, {31'h0, (!r && m_park.size() == 0)});
         check_eq("if_pc", if_pc, m_pc);
         check_eq("imem_addr", imem_addr, m_pc);
         check_eq("id_valid", {31'h0, id_valid}, {31'h0, m_id_valid});
         check_eq("id_pc", id_pc, m_id_pc);
         check_eq("id_instr", id_instr, m_id_instr);
      end
      @(posedge clk);
      model_edge();
      #1;
   endtask

   initial begin
      rst = 1'b1; stall = 1'b0; flush = 1'b0; new_pc = 32'h0;
      imem_ready = 1'b1; imem_rdata = 32'h0;
      @(posedge clk);
      #1;

      // Reset, then first fetch retires into ID.
      cyc(1, 0, 0, 1, 32'h0);
      cyc(1, 0, 0, 1, 32'h0);
      check_eq("rst_addr", imem_addr, 32'h0000_3000);
      check_eq("rst_id_valid", {31'h0, id_valid}, 32'h0);
      cyc(0, 0, 0, 1, plus4(m_pc));
      check_eq("first_id_pc", id_pc, 32'h0000_3000);
      check_eq("first_id_valid", {31'h0, id_valid}, 32'h1);
      cyc(0, 0, 0, 1, plus4(m_pc));
      check_eq("stream_id_pc", id_pc, 32'h0000_3004);

      // Two wait states at 0x3008.
      cyc(0, 0, 0, 0, plus4(m_pc));
      cyc(0, 0, 0, 0, plus4(m_pc));
      check_eq("wait_addr", imem_addr, 32'h0000_3008);
      check_eq("wait_bubble", {31'h0, id_valid}, 32'h0);
      cyc(0, 0, 0, 1, plus4(m_pc));
      check_eq("wait_id_pc", id_pc, 32'h0000_3008);

      // Stall on retire at 0x300C for three cycles, release from the buffer.
      cyc(0, 1, 0, 1, plus4(m_pc));
      check_eq("hold_req", {31'h0, imem_req}, 32'h0);
      cyc(0, 1, 0, 1, plus4(m_pc));
      cyc(0, 1, 0, 1, plus4(m_pc));
      check_eq("hold_id_pc", id_pc, 32'h0000_3008);
      cyc(0, 0, 0, 1, plus4(m_pc));
      check_eq("release_id_pc", id_pc, 32'h0000_300C);
      check_eq("release_addr", imem_addr, 32'h0000_3010);

      // Flush while waiting at 0x3010.
      cyc(0, 0, 1, 0, 32'h0000_3100);
      cyc(0, 0, 0, 0, plus4(m_pc));
      check_eq("drop_addr", imem_addr, 32'h0000_3010);
      cyc(0, 0, 0, 1, plus4(m_pc));
      check_eq("redir_addr", imem_addr, 32'h0000_3100);
      check_eq("redir_bubble", {31'h0, id_valid}, 32'h0);

      // Flush beats stall in HOLD, then reset while dropping.
      cyc(0, 1, 0, 1, plus4(m_pc));
      cyc(0, 1, 1, 1, 32'h0000_3200);
      check_eq("flush_hold_pc", if_pc, 32'h0000_3200);
      check_eq("flush_hold_valid", {31'h0, id_valid}, 32'h0);
      cyc(0, 0, 1, 0, 32'h0000_3300);
      cyc(1, 0, 0, 0, 32'h0);
      check_eq("rst_drop_pc", if_pc, 32'h0000_3000);
      cyc(0, 0, 0, 1, plus4(m_pc));
      check_eq("rst_drop_id_pc", id_pc, 32'h0000_3000);

      // Randomized traffic.
      for (int i = 0; i < 3000; i++) begin
         logic r, s, f, rdy;
         logic [31:0] npc;
         r   = ($urandom_range(0, 99) < 2);
         s   = ($urandom_range(0, 99) < 25);
         f   = ($urandom_range(0, 99) < 10);
         rdy = ($urandom_range(0, 99) < 65);
         npc = f ? {$urandom_range(0, 16'hFFFF), 2'b00} : plus4(m_pc);
         cyc(r, s, f, rdy, npc);
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
